// File: rtl/imem_loader_ctrl.sv
// -----------------------------------------------------------------------------
// imem_loader_ctrl
//
// Boot-time instruction memory loader. Consumes a byte stream (valid/ready),
// parses a 4-byte little-endian word-count header, assembles little-endian
// 32-bit instructions and issues one BRAM write per word. The core is held
// off (cpu_hold) until a complete image has been written.
//
// Optional build macro:
//   IMEM_LOADER_CSUM_EN  After the last data byte, one extra checksum byte is
//                        accepted. It must equal the XOR of all data bytes
//                        (header excluded); a mismatch ends in the error state
//                        with the core still held.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   start        1-cycle load request, honoured only in IDLE or ERR
//   rx_valid     byte available on rx_data
//   rx_data      stream byte
//   rx_ready     byte accepted when rx_valid && rx_ready (registered)
//   is_write     BRAM write strobe, one cycle per word
//   im_addr      BRAM byte address (word aligned)
//   im_inst      BRAM write data
//   cpu_hold     1 = core must not fetch/execute
//   busy         1 while receiving header, data or checksum
//   loaded       last load completed OK (cleared by start)
//   err          last load failed (cleared by start)
//   words_loaded words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader_ctrl #(
    parameter int             W             = 32,
    parameter int             DEPTH_WORDS   = 2048,
    parameter logic [W-1:0]   BASE_ADDR     = '0,
    parameter bit             HOLD_AT_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         rx_ready,
    output logic         is_write,
    output logic [W-1:0] im_addr,
    output logic [W-1:0] im_inst,
    output logic         cpu_hold,
    output logic         busy,
    output logic         loaded,
    output logic         err,
    output logic [15:0]  words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERR
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   byte_idx_q, byte_idx_d;
    logic [31:0]  len_q, len_d;
    logic [31:0]  word_q, word_d;
    logic [W-1:0] next_addr_q, next_addr_d;
    logic [W-1:0] im_addr_q, im_addr_d;
    logic [W-1:0] im_inst_q, im_inst_d;
    logic         is_write_q, is_write_d;
    logic         active_q, active_d;
    logic         loaded_q, loaded_d;
    logic         err_q, err_d;
    logic         cpu_hold_q, cpu_hold_d;
    logic [15:0]  words_loaded_q, words_loaded_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]   csum_q, csum_d;
`endif

    logic         accept;
    logic [31:0]  len_shift;
    logic [31:0]  word_shift;
    logic [15:0]  words_inc;

    // rx_ready comes from a flop, so acceptance never depends combinationally
    // on rx_valid reaching back into rx_ready.
    assign accept     = rx_valid && active_q;
    // Bytes arrive LSB first: each new byte enters at the top and the
    // accumulated value shifts down, so after four bytes byte 0 sits in [7:0].
    assign len_shift  = {rx_data, len_q[31:8]};
    assign word_shift = {rx_data, word_q[31:8]};
    assign words_inc  = words_loaded_q + 16'd1;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        len_d          = len_q;
        word_d         = word_q;
        next_addr_d    = next_addr_q;
        im_addr_d      = im_addr_q;
        im_inst_d      = im_inst_q;
        is_write_d     = 1'b0;
        loaded_d       = loaded_q;
        err_d          = err_q;
        cpu_hold_d     = cpu_hold_q;
        words_loaded_d = words_loaded_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d         = csum_q;
`endif

        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d        = ST_LEN;
                    byte_idx_d     = 2'd0;
                    len_d          = '0;
                    word_d         = '0;
                    next_addr_d    = BASE_ADDR;
                    loaded_d       = 1'b0;
                    err_d          = 1'b0;
                    cpu_hold_d     = 1'b1;
                    words_loaded_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d         = '0;
`endif
                end
            end

            ST_LEN: begin
                if (accept) begin
                    len_d      = len_shift;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (len_shift == 32'd0) begin
                            state_d = ST_DONE;
                        end else if (len_shift > 32'(DEPTH_WORDS)) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    word_d     = word_shift;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        // Word complete: registered write lands next cycle.
                        is_write_d     = 1'b1;
                        im_addr_d      = next_addr_q;
                        im_inst_d      = W'(word_shift);
                        next_addr_d    = next_addr_q + W'(4);
                        words_loaded_d = words_inc;
                        if ({16'd0, words_inc} == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
            end

`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // Words already written stay written; core stays held.
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif

            ST_DONE: begin
                state_d    = ST_IDLE;
                loaded_d   = 1'b1;
                cpu_hold_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // rx_ready and busy are the same condition; registering the decode of
        // the next state keeps them aligned with state_q.
`ifdef IMEM_LOADER_CSUM_EN
        active_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
`else
        active_d = (state_d == ST_LEN) || (state_d == ST_DATA);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // asynchronous reset returns every output to its idle value immediately,
    // abandoning any partial word so no further write can be issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            byte_idx_q     <= 2'd0;
            len_q          <= '0;
            word_q         <= '0;
            next_addr_q    <= BASE_ADDR;
            im_addr_q      <= BASE_ADDR;
            im_inst_q      <= '0;
            is_write_q     <= 1'b0;
            active_q       <= 1'b0;
            loaded_q       <= 1'b0;
            err_q          <= 1'b0;
            cpu_hold_q     <= HOLD_AT_RESET;
            words_loaded_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            byte_idx_q     <= byte_idx_d;
            len_q          <= len_d;
            word_q         <= word_d;
            next_addr_q    <= next_addr_d;
            im_addr_q      <= im_addr_d;
            im_inst_q      <= im_inst_d;
            is_write_q     <= is_write_d;
            active_q       <= active_d;
            loaded_q       <= loaded_d;
            err_q          <= err_d;
            cpu_hold_q     <= cpu_hold_d;
            words_loaded_q <= words_loaded_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign rx_ready     = active_q;
    assign busy         = active_q;
    assign is_write     = is_write_q;
    assign im_addr      = im_addr_q;
    assign im_inst      = im_inst_q;
    assign cpu_hold     = cpu_hold_q;
    assign loaded       = loaded_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_loader_ctrl
//
// Directed self-checking bench for imem_loader_ctrl (default parameters).
// Expected BRAM writes are pushed to a scoreboard queue as each data word is
// driven; a monitor pops and compares them whenever is_write is seen.
// Build with +define+IMEM_LOADER_CSUM_EN to exercise the checksum byte.
// -----------------------------------------------------------------------------
module tb_imem_loader_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        is_write;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        cpu_hold;
    logic        busy;
    logic        loaded;
    logic        err;
    logic [15:0] words_loaded;

    imem_loader_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .is_write     (is_write),
        .im_addr      (im_addr),
        .im_inst      (im_inst),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .loaded       (loaded),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cnt;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          tests  = 0;
    int          failed = 0;
    int          exp_k;
    logic [7:0]  exp_csum;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Write monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (is_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, is_write}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", im_addr, mon_e.addr);
                check("wr_data", im_inst, mon_e.data);
                check("wr_count", {16'd0, words_loaded}, {16'd0, mon_e.cnt});
            end
        end
    end

    // All directed steps run in the phase just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic begin_load();
        exp_k    = 0;
        exp_csum = 8'h00;
        pulse_start();
    endtask

    task automatic send_header(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic send_data_word(input logic [31:0] w, input bit gap);
        wr_t e;
        e.addr = 32'(exp_k) * 32'd4;
        e.data = w;
        e.cnt  = 16'(exp_k + 1);
        exp_q.push_back(e);
        exp_k++;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            exp_csum = exp_csum ^ w[8*i +: 8];
            if (gap) step();
        end
    endtask

    task automatic send_csum(input logic [7:0] flip);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(exp_csum ^ flip);
`else
        if (flip != 8'h00) step();
`endif
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(loaded || err) && n < 30) begin
            step();
            n++;
        end
        if (!(loaded || err)) check("end_timeout", {31'd0, loaded | err}, 32'd1);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // 1. Reset state
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_is_write", {31'd0, is_write}, 32'd0);
        check("rst_loaded",   {31'd0, loaded},   32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_im_addr",  im_addr,           32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // 2. Two-word image, back-to-back bytes
        begin_load();
        check("t2_busy",     {31'd0, busy},     32'd1);
        check("t2_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("t2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        send_header(32'd2);
        send_data_word(32'h0000_0013, 1'b0);
        send_data_word(32'h0010_0093, 1'b0);
        send_csum(8'h00);
        wait_end();
        check("t2_loaded",   {31'd0, loaded},       32'd1);
        check("t2_err",      {31'd0, err},          32'd0);
        check("t2_cpu_hold_rel", {31'd0, cpu_hold}, 32'd0);
        check("t2_words",    {16'd0, words_loaded}, 32'd2);
        check("t2_im_addr_hold", im_addr,           32'h4);
        // A stray byte after completion must not be taken.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        step();
        check("t2_no_extra_byte", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;

        // 3a. Zero-length image
        begin_load();
        check("t3_loaded_cleared", {31'd0, loaded}, 32'd0);
        send_header(32'd0);
        wait_end();
        check("t3_zero_loaded", {31'd0, loaded},       32'd1);
        check("t3_zero_words",  {16'd0, words_loaded}, 32'd0);
        check("t3_zero_hold",   {31'd0, cpu_hold},     32'd0);

        // 3b. Oversize header (2049) -> error, core held, no write
        begin_load();
        send_header(32'd2049);
        wait_end();
        check("t3_err",      {31'd0, err},      32'd1);
        check("t3_err_hold", {31'd0, cpu_hold}, 32'd1);
        check("t3_err_ld",   {31'd0, loaded},   32'd0);
        check("t3_err_busy", {31'd0, busy},     32'd0);
        check("t3_err_rdy",  {31'd0, rx_ready}, 32'd0);
        repeat (3) step();
        check("t3_err_sticky", {31'd0, err}, 32'd1);
        begin_load();
        check("t3_err_clear",  {31'd0, err},  32'd0);
        check("t3_err_busy2",  {31'd0, busy}, 32'd1);
        send_header(32'd0);
        wait_end();
        check("t3_recover", {31'd0, loaded}, 32'd1);

        // 4. Gapped bytes with a start pulse mid-DATA
        begin_load();
        send_header(32'd2);
        send_data_word(32'h0000_0013, 1'b1);
        pulse_start();
        check("t4_start_ign_busy", {31'd0, busy},   32'd1);
        check("t4_start_ign_ld",   {31'd0, loaded}, 32'd0);
        send_data_word(32'h0010_0093, 1'b1);
        send_csum(8'h00);
        wait_end();
        check("t4_loaded", {31'd0, loaded},       32'd1);
        check("t4_words",  {16'd0, words_loaded}, 32'd2);

        // Boundary: header equal to DEPTH_WORDS is accepted
        begin_load();
        send_header(32'd2048);
        step();
        check("bnd_depth_busy", {31'd0, busy}, 32'd1);
        check("bnd_depth_err",  {31'd0, err},  32'd0);
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // 5. Reset after 5 data bytes: immediate reset values, no partial write
        begin_load();
        send_header(32'd2);
        send_data_word(32'h0000_0013, 1'b0);
        send_byte(8'h93);
        #2 rst = 1'b1;
        #1;
        check("t5_is_write",  {31'd0, is_write},     32'd0);
        check("t5_rx_ready",  {31'd0, rx_ready},     32'd0);
        check("t5_busy",      {31'd0, busy},         32'd0);
        check("t5_loaded",    {31'd0, loaded},       32'd0);
        check("t5_err",       {31'd0, err},          32'd0);
        check("t5_im_addr",   im_addr,               32'd0);
        check("t5_im_inst",   im_inst,               32'd0);
        check("t5_words",     {16'd0, words_loaded}, 32'd0);
        check("t5_cpu_hold",  {31'd0, cpu_hold},     32'd1);
        step();
        rst      = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        repeat (6) step();
        check("t5_idle_no_rdy", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;

`ifdef IMEM_LOADER_CSUM_EN
        // 6. Checksum mismatch -> error, core held
        begin_load();
        send_header(32'd2);
        send_data_word(32'h0000_0013, 1'b0);
        send_data_word(32'h0010_0093, 1'b0);
        send_csum(8'h01);
        wait_end();
        check("t6_csum_err",  {31'd0, err},      32'd1);
        check("t6_csum_hold", {31'd0, cpu_hold}, 32'd1);
        check("t6_csum_ld",   {31'd0, loaded},   32'd0);
`endif

        repeat (3) step();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
